// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM states and sign/magnitude helper for the repeated-subtraction divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Width the sign helper works at; callers zero-extend in and size-cast the result back.
  localparam int DIV_MAX_W = 64;

  function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] v,
                                                    input logic                 neg);
    return neg ? (~v + DIV_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - IDLE/CALC/DONE sequencer issuing load/inc/fin strobes to the datapath
module div_ctrl
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_lesser,
  input  logic i_zero,
  output logic o_load,
  output logic o_inc,
  output logic o_fin,
  output logic o_busy,
  output logic o_done
);

  div_state_t r_state;
  div_state_t w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_load = 1'b0;
    o_inc  = 1'b0;
    o_fin  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          o_load = 1'b1;
          w_next = CALC;
        end
      end
      CALC: begin
        // A zero divisor must finish before the comparison, which would always pass.
        if (i_zero || i_lesser) begin
          o_fin  = 1'b1;
          w_next = DONE;
        end else begin
          o_inc = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == DONE);

endmodule

// File: rtl/div_dp.sv
// rtl/div_dp.sv - magnitude registers, compare/subtract, quotient counter and final sign fix
module div_dp
  import div_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic             i_fin,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_lesser,
  output logic             o_zero,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_dbz,
  output logic             o_ovf
);

  localparam bit               IS_SIGNED = (SIGNED != 0);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] r_rem, r_cnt, r_dvs, r_quot_out, r_rem_out;
  logic             r_sign_a, r_sign_b, r_dbz, r_ovf;

  logic             w_sign_a, w_sign_b, w_ovf;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_quot_fix, w_rem_fix;

  assign w_sign_a = IS_SIGNED & i_dividend[WIDTH-1];
  assign w_sign_b = IS_SIGNED & i_divisor[WIDTH-1];
  assign w_mag_a  = WIDTH'(cond_neg(DIV_MAX_W'(i_dividend), w_sign_a));
  assign w_mag_b  = WIDTH'(cond_neg(DIV_MAX_W'(i_divisor), w_sign_b));

  assign o_zero   = (r_dvs == '0);
  assign o_lesser = (r_rem < r_dvs);

  // Remainder follows the dividend sign; this also rebuilds the raw dividend for divide-by-zero.
  assign w_quot_fix = WIDTH'(cond_neg(DIV_MAX_W'(r_cnt), r_sign_a ^ r_sign_b));
  assign w_rem_fix  = WIDTH'(cond_neg(DIV_MAX_W'(r_rem), r_sign_a));
  // Only -2^(W-1) / -1 can reach a count of 2^(W-1) with both signs negative.
  assign w_ovf      = IS_SIGNED & r_sign_a & r_sign_b & (r_cnt == MIN_NEG);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem      <= '0;
      r_cnt      <= '0;
      r_dvs      <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_quot_out <= '0;
      r_rem_out  <= '0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (i_load) begin
      r_rem    <= w_mag_a;
      r_cnt    <= '0;
      r_dvs    <= w_mag_b;
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (i_inc) begin
      r_rem <= r_rem - r_dvs;
      r_cnt <= r_cnt + WIDTH'(1);
    end else if (i_fin) begin
      if (o_zero) begin
        r_dbz      <= 1'b1;
        r_quot_out <= '1;
      end else begin
        r_quot_out <= w_quot_fix;
        r_ovf      <= w_ovf;
      end
      r_rem_out <= w_rem_fix;
    end
  end

  assign o_quotient  = r_quot_out;
  assign o_remainder = r_rem_out;
  assign o_dbz       = r_dbz;
  assign o_ovf       = r_ovf;

endmodule

// File: rtl/div_rep_sub_param.sv
// rtl/div_rep_sub_param.sv - repeated-subtraction divider, one subtraction per cycle
module div_rep_sub_param
  import div_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             ovf
);

  logic w_load, w_inc, w_fin, w_lesser, w_zero;

  div_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .i_start  (start),
    .i_lesser (w_lesser),
    .i_zero   (w_zero),
    .o_load   (w_load),
    .o_inc    (w_inc),
    .o_fin    (w_fin),
    .o_busy   (busy),
    .o_done   (done)
  );

  div_dp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_dp (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_inc       (w_inc),
    .i_fin       (w_fin),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_lesser    (w_lesser),
    .o_zero      (w_zero),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_dbz       (dbz),
    .o_ovf       (ovf)
  );

endmodule

// File: tb/tb_div_rep_sub_param.sv
// tb/tb_div_rep_sub_param.sv - self-checking bench for unsigned and signed divider instances
module tb_div_rep_sub_param;

  localparam int W     = 16;
  localparam int LIMIT = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         u_start, u_busy, u_done, u_dbz, u_ovf;
  logic [W-1:0] u_dividend, u_divisor, u_quotient, u_remainder;
  logic         s_start, s_busy, s_done, s_dbz, s_ovf;
  logic [W-1:0] s_dividend, s_divisor, s_quotient, s_remainder;

  int checks   = 0;
  int failures = 0;

  div_rep_sub_param #(.WIDTH(W), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(u_start), .dividend(u_dividend), .divisor(u_divisor),
    .busy(u_busy), .done(u_done), .quotient(u_quotient), .remainder(u_remainder),
    .dbz(u_dbz), .ovf(u_ovf)
  );

  div_rep_sub_param #(.WIDTH(W), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(s_start), .dividend(s_dividend), .divisor(s_divisor),
    .busy(s_busy), .done(s_done), .quotient(s_quotient), .remainder(s_remainder),
    .dbz(s_dbz), .ovf(s_ovf)
  );

  // Drivers: issue one start, scramble operands after acceptance, return cycles to done (-1 on timeout).
  task automatic run_u(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (u_busy && guard < 4) begin @(negedge clk); guard++; end
    u_dividend = a; u_divisor = b; u_start = 1'b1;
    @(posedge clk); #1;
    u_start = 1'b0; u_dividend = W'($urandom); u_divisor = W'($urandom);
    lat = 0;
    while (!u_done && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    if (!u_done) lat = -1;
  endtask

  task automatic run_s(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (s_busy && guard < 4) begin @(negedge clk); guard++; end
    s_dividend = a; s_divisor = b; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_dividend = W'($urandom); s_divisor = W'($urandom);
    lat = 0;
    while (!s_done && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    if (!s_done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_start = 1'b0; u_dividend = '0; u_divisor = '0;
    s_start = 1'b0; s_dividend = '0; s_divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({u_busy, u_done, u_dbz, u_ovf} !== 4'b0) begin failures++;
      $display("FAIL reset_u_flags: got %b expected 0000", {u_busy, u_done, u_dbz, u_ovf}); end
    checks++; if ({u_quotient, u_remainder} !== '0) begin failures++;
      $display("FAIL reset_u_qr: got %h/%h expected 0/0", u_quotient, u_remainder); end
    checks++; if ({s_busy, s_done, s_dbz, s_ovf} !== 4'b0) begin failures++;
      $display("FAIL reset_s_flags: got %b expected 0000", {s_busy, s_done, s_dbz, s_ovf}); end
    checks++; if ({s_quotient, s_remainder} !== '0) begin failures++;
      $display("FAIL reset_s_qr: got %h/%h expected 0/0", s_quotient, s_remainder); end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (u_busy !== 1'b0 || u_quotient !== '0) begin failures++;
      $display("FAIL idle_hold: got busy=%b q=%h expected busy=0 q=0", u_busy, u_quotient); end
  endtask

  task automatic test_unsigned_directed();
    int da[4] = '{100, 7, 9, 55};
    int db[4] = '{3, 9, 9, 0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      int eq, er, el, ez;
      if (db[i] == 0) begin eq = 'hFFFF; er = da[i]; el = 1; ez = 1; end
      else begin eq = da[i] / db[i]; er = da[i] % db[i]; el = eq + 1; ez = 0; end
      run_u(W'(da[i]), W'(db[i]), lat);
      checks++; if (lat !== el) begin failures++;
        $display("FAIL u_dir_lat[%0d]: got %0d expected %0d", i, lat, el); end
      checks++; if (u_quotient !== W'(eq)) begin failures++;
        $display("FAIL u_dir_q[%0d]: got %h expected %h", i, u_quotient, W'(eq)); end
      checks++; if (u_remainder !== W'(er)) begin failures++;
        $display("FAIL u_dir_r[%0d]: got %h expected %h", i, u_remainder, W'(er)); end
      checks++; if (u_dbz !== ez[0] || u_ovf !== 1'b0) begin failures++;
        $display("FAIL u_dir_flags[%0d]: got dbz=%b ovf=%b expected dbz=%0d ovf=0", i, u_dbz, u_ovf, ez); end
    end
  endtask

  task automatic test_signed_directed();
    int da[5] = '{-100, 100, -100, -7, -32768};
    int db[5] = '{3, -3, -3, 0, -1};
    int lat;
    for (int i = 0; i < 5; i++) begin
      int eq, er, el, ez, eo, ma, mb;
      ma = (da[i] < 0) ? -da[i] : da[i];
      mb = (db[i] < 0) ? -db[i] : db[i];
      ez = (db[i] == 0) ? 1 : 0;
      eo = (da[i] == -32768 && db[i] == -1) ? 1 : 0;
      if (ez == 1) begin eq = -1; er = da[i]; el = 1; end
      else begin eq = da[i] / db[i]; er = da[i] % db[i]; el = ma / mb + 1; end
      run_s(W'(da[i]), W'(db[i]), lat);
      checks++; if (lat !== el) begin failures++;
        $display("FAIL s_dir_lat[%0d]: got %0d expected %0d", i, lat, el); end
      checks++; if (s_quotient !== W'(eq)) begin failures++;
        $display("FAIL s_dir_q[%0d]: got %h expected %h", i, s_quotient, W'(eq)); end
      checks++; if (s_remainder !== W'(er)) begin failures++;
        $display("FAIL s_dir_r[%0d]: got %h expected %h", i, s_remainder, W'(er)); end
      checks++; if (s_dbz !== ez[0] || s_ovf !== eo[0]) begin failures++;
        $display("FAIL s_dir_flags[%0d]: got dbz=%b ovf=%b expected dbz=%0d ovf=%0d", i, s_dbz, s_ovf, ez, eo); end
    end
  endtask

  task automatic test_unsigned_random();
    int lat;
    for (int i = 0; i < 24; i++) begin
      int a, b, eq, er, el, ez, amax;
      b = (i % 8 == 7) ? 0 : int'($urandom_range(1, 65535));
      amax = (b == 0 || b * 200 > 65535) ? 65535 : b * 200;
      a = int'($urandom_range(0, amax));
      if (b == 0) begin eq = 'hFFFF; er = a; el = 1; ez = 1; end
      else begin eq = a / b; er = a % b; el = eq + 1; ez = 0; end
      run_u(W'(a), W'(b), lat);
      checks++; if (lat !== el || u_dbz !== ez[0]) begin failures++;
        $display("FAIL u_rand_lat[%0d] %0d/%0d: got lat=%0d dbz=%b expected lat=%0d dbz=%0d", i, a, b, lat, u_dbz, el, ez); end
      checks++; if (u_quotient !== W'(eq) || u_remainder !== W'(er)) begin failures++;
        $display("FAIL u_rand_qr[%0d] %0d/%0d: got %h/%h expected %h/%h", i, a, b, u_quotient, u_remainder, W'(eq), W'(er)); end
    end
  endtask

  task automatic test_signed_random();
    int lat;
    for (int i = 0; i < 24; i++) begin
      int ma, mb, sa, sb, eq, er, el, ez, amax;
      mb = (i % 8 == 5) ? 0 : int'($urandom_range(1, 32768));
      amax = (mb == 0 || mb * 200 > 32768) ? 32768 : mb * 200;
      ma = int'($urandom_range(0, amax));
      sa = ($urandom_range(0, 1) == 1 || ma == 32768) ? -ma : ma;
      sb = ($urandom_range(0, 1) == 1 || mb == 32768) ? -mb : mb;
      if (sb == 0) begin eq = -1; er = sa; el = 1; ez = 1; end
      else begin eq = sa / sb; er = sa % sb; el = ma / mb + 1; ez = 0; end
      run_s(W'(sa), W'(sb), lat);
      checks++; if (lat !== el || s_dbz !== ez[0] || s_ovf !== 1'b0) begin failures++;
        $display("FAIL s_rand_lat[%0d] %0d/%0d: got lat=%0d dbz=%b ovf=%b expected lat=%0d dbz=%0d ovf=0", i, sa, sb, lat, s_dbz, s_ovf, el, ez); end
      checks++; if (s_quotient !== W'(eq) || s_remainder !== W'(er)) begin failures++;
        $display("FAIL s_rand_qr[%0d] %0d/%0d: got %h/%h expected %h/%h", i, sa, sb, s_quotient, s_remainder, W'(eq), W'(er)); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, busy_seen;
    @(negedge clk);
    u_dividend = W'(100); u_divisor = W'(3); u_start = 1'b1;
    @(posedge clk); #1;
    u_start = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    u_dividend = W'(7); u_divisor = W'(1); u_start = 1'b1;
    @(posedge clk); #1; lat++;
    u_start = 1'b0;
    while (!u_done && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    checks++; if (!u_done || lat !== 34) begin failures++;
      $display("FAIL busy_lat: got done=%b lat=%0d expected done=1 lat=34", u_done, lat); end
    checks++; if (u_quotient !== W'(33) || u_remainder !== W'(1)) begin failures++;
      $display("FAIL busy_qr: got %0d/%0d expected 33/1", u_quotient, u_remainder); end
    // A start raised during DONE must not launch or queue anything.
    u_start = 1'b1;
    @(posedge clk); #1;
    u_start = 1'b0;
    busy_seen = 0;
    repeat (8) begin
      if (u_busy || u_done) busy_seen++;
      @(posedge clk); #1;
    end
    checks++; if (busy_seen !== 0) begin failures++;
      $display("FAIL busy_no_queue: got %0d busy cycles expected 0", busy_seen); end
    checks++; if (u_quotient !== W'(33) || u_remainder !== W'(1)) begin failures++;
      $display("FAIL result_hold: got %0d/%0d expected 33/1", u_quotient, u_remainder); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    u_dividend = W'(100);  u_divisor = W'(3); u_start = 1'b1;
    s_dividend = W'(-100); s_divisor = W'(0); s_start = 1'b0;
    @(posedge clk); #1;
    u_start = 1'b0;
    // Signed instance first gets a dbz result, then an aborted operation.
    run_s(W'(-5), W'(0), lat);
    @(negedge clk);
    s_dividend = W'(-100); s_divisor = W'(3); s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; u_start = 1'b1; s_start = 1'b1;
    @(posedge clk); #1;
    checks++; if ({u_busy, u_done, u_dbz, u_ovf} !== 4'b0 || {u_quotient, u_remainder} !== '0) begin failures++;
      $display("FAIL mid_rst_u: got busy=%b done=%b q=%h r=%h expected all 0", u_busy, u_done, u_quotient, u_remainder); end
    checks++; if ({s_busy, s_done, s_dbz, s_ovf} !== 4'b0 || {s_quotient, s_remainder} !== '0) begin failures++;
      $display("FAIL mid_rst_s: got busy=%b done=%b dbz=%b q=%h r=%h expected all 0", s_busy, s_done, s_dbz, s_quotient, s_remainder); end
    @(negedge clk);
    rst = 1'b0; u_start = 1'b0; s_start = 1'b0;
    run_u(W'(100), W'(3), lat);
    checks++; if (lat !== 34 || u_quotient !== W'(33) || u_remainder !== W'(1) || u_dbz !== 1'b0) begin failures++;
      $display("FAIL post_rst_u: got lat=%0d q=%0d r=%0d dbz=%b expected 34/33/1/0", lat, u_quotient, u_remainder, u_dbz); end
    run_s(W'(-100), W'(3), lat);
    checks++; if (lat !== 34 || s_quotient !== W'(-33) || s_remainder !== W'(-1) || s_dbz !== 1'b0) begin failures++;
      $display("FAIL post_rst_s: got lat=%0d q=%h r=%h dbz=%b expected 34/ffdf/ffff/0", lat, s_quotient, s_remainder, s_dbz); end
  endtask

  initial begin
    test_reset();
    test_unsigned_directed();
    test_signed_directed();
    test_unsigned_random();
    test_signed_random();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
